mem_bist_ctrl: RTL and testbench

//   March C- built-in self-test initiator for the 16x32 synchronous memory.

---
 rtl/mem_bist_pkg.sv | 38 +++
 rtl/mem_bist_addr_gen.sv | 42 ++++
 rtl/mem_bist_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared state encoding and March C- element table for the memory BIST controller.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        CMP,
        DONE
    } state_t;

    typedef struct packed {
        logic dir_up;
        logic has_rd;
        logic rd_one;
        logic has_wr;
        logic wr_one;
    } elem_t;

    localparam int         N_ELEM    = 6;
    localparam logic [2:0] LAST_ELEM = 3'd5;

    // Fields: dir_up, has_rd, rd_one, has_wr, wr_one
    localparam elem_t MARCH_TABLE [N_ELEM] = '{
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},   // E0 up(w0)
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},   // E1 up(r0,w1)
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},   // E2 up(r1,w0)
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},   // E3 down(r0,w1)
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},   // E4 down(r1,w0)
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}    // E5 down(r0)
    };

    function automatic logic [2:0] next_elem(input logic [2:0] cur);
        return (cur == LAST_ELEM) ? cur : cur + 3'd1;
    endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// March sweep address counter: load jumps to the first address of the sweep direction,
// step moves one word, last flags the final address of the current sweep.
module mem_bist_addr_gen #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          load_up,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [AW-1:0] addr_q, addr_d;
    logic          up_q, up_d;

    always_comb begin
        addr_d = addr_q;
        up_d   = up_q;
        if (load) begin
            up_d   = load_up;
            addr_d = load_up ? '0 : '1;
        end else if (step) begin
            addr_d = up_q ? addr_q + 1'b1 : addr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            up_q   <= 1'b1;
        end else begin
            addr_q <= addr_d;
            up_q   <= up_d;
        end
    end

    assign addr = addr_q;
    assign last = up_q ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST initiator for a synchronous single-port memory; reports busy/done/fail.
// Define MEM_BIST_ERR_LOG_EN to build the first-failure log and mismatch counter on err_*.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int            DW     = 32,
    parameter int            AW     = 4,
    parameter int            RD_LAT = 1,
    parameter logic [DW-1:0] BG     = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [DW-1:0] mem_d_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en_wr,
    output logic          mem_en_rd,
    input  logic [DW-1:0] mem_d_out,
    output logic [AW-1:0] err_addr,
    output logic [DW-1:0] err_exp,
    output logic [DW-1:0] err_got,
    output logic [7:0]    err_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 2);

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d, elem_nx;
    logic [7:0]    wait_q, wait_d;
    logic          busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic          en_wr_q, en_wr_d, en_rd_q, en_rd_d;
    logic [DW-1:0] d_in_q, d_in_d;
    logic          ag_load, ag_load_up, ag_step, ag_last;
    logic [AW-1:0] ag_addr;
    logic          start_run, mismatch;
    elem_t         cur_e, nxt_e, out_e;
    logic [DW-1:0] exp_data;

    assign elem_nx   = next_elem(elem_q);
    assign cur_e     = MARCH_TABLE[elem_q];
    assign nxt_e     = MARCH_TABLE[elem_nx];
    assign exp_data  = cur_e.rd_one ? ~BG : BG;
    assign mismatch  = (state_q == CMP) && (mem_d_out != exp_data);
    assign start_run = ((state_q == IDLE) || (state_q == DONE)) && start;

    mem_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (ag_load),
        .load_up (ag_load_up),
        .step    (ag_step),
        .addr    (ag_addr),
        .last    (ag_last)
    );

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        wait_d     = wait_q;
        done_d     = done_q;
        fail_d     = fail_q | mismatch;
        ag_load    = 1'b0;
        ag_load_up = 1'b1;
        ag_step    = 1'b0;
        out_e      = cur_e;
        case (state_q)
            IDLE, DONE: begin
                if (start_run) begin
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    elem_d     = 3'd0;
                    ag_load    = 1'b1;
                    ag_load_up = MARCH_TABLE[0].dir_up;
                    state_d    = MARCH_TABLE[0].has_rd ? RD : WR;
                end
            end
            // A sweep ends on its last address; the next element reloads the counter.
            WR, CMP: begin
                if (!ag_last) begin
                    ag_step = 1'b1;
                    state_d = cur_e.has_rd ? RD : WR;
                end else if (elem_q == LAST_ELEM) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    elem_d     = elem_nx;
                    ag_load    = 1'b1;
                    ag_load_up = nxt_e.dir_up;
                    state_d    = nxt_e.has_rd ? RD : WR;
                end
            end
            RD: begin
                wait_d  = 8'd0;
                state_d = (RD_LAT == 1) ? CMP : WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) state_d = CMP;
                else                     wait_d  = wait_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        if (elem_d != elem_q) out_e = nxt_e;
        busy_d  = (state_d == WR) || (state_d == RD) || (state_d == WAIT) || (state_d == CMP);
        en_rd_d = (state_d == RD);
        en_wr_d = (state_d == WR) || ((state_d == CMP) && out_e.has_wr);
        d_in_d  = en_wr_d ? (out_e.wr_one ? ~BG : BG) : d_in_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            elem_q  <= 3'd0;
            wait_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            en_wr_q <= 1'b0;
            en_rd_q <= 1'b0;
            d_in_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            en_wr_q <= en_wr_d;
            en_rd_q <= en_rd_d;
            d_in_q  <= d_in_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign mem_d_in  = d_in_q;
    assign mem_addr  = ag_addr;
    assign mem_en_wr = en_wr_q;
    assign mem_en_rd = en_rd_q;

`ifdef MEM_BIST_ERR_LOG_EN
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [DW-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // A zero count marks "nothing logged yet"; the count saturates so it never wraps back.
    always_comb begin
        err_addr_d = err_addr_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        err_cnt_d  = err_cnt_q;
        if (start_run) begin
            err_addr_d = '0;
            err_exp_d  = '0;
            err_got_d  = '0;
            err_cnt_d  = 8'd0;
        end else if (mismatch) begin
            if (err_cnt_q == 8'd0) begin
                err_addr_d = ag_addr;
                err_exp_d  = exp_data;
                err_got_d  = mem_d_out;
            end
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;
    assign err_cnt  = err_cnt_q;
`else
    assign err_addr = '0;
    assign err_exp  = '0;
    assign err_got  = '0;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: faulty-memory models, directed vector table, random fault runs,
// mid-run reset and a second instance built with a two-cycle read latency.
module tb_mem_bist_ctrl;

    localparam int            DW    = 32;
    localparam int            AW    = 4;
    localparam int            DEPTH = 16;
    localparam logic [DW-1:0] BG    = '0;
    localparam int            OPW   = 2 + AW + DW;
`ifdef MEM_BIST_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic start0, start1;

    logic          busy0, done0, fail0, wr0, rd0;
    logic [DW-1:0] d_in0, d_out0, err_exp0, err_got0;
    logic [AW-1:0] addr0, err_addr0;
    logic [7:0]    err_cnt0;
    logic          busy1, done1, fail1, wr1, rd1;
    logic [DW-1:0] d_in1, d_out1, err_exp1, err_got1;
    logic [AW-1:0] addr1, err_addr1;
    logic [7:0]    err_cnt1;

    mem_bist_ctrl #(.DW(DW), .AW(AW), .RD_LAT(1), .BG(BG)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .fail(fail0),
        .mem_d_in(d_in0), .mem_addr(addr0), .mem_en_wr(wr0), .mem_en_rd(rd0),
        .mem_d_out(d_out0), .err_addr(err_addr0), .err_exp(err_exp0),
        .err_got(err_got0), .err_cnt(err_cnt0)
    );

    mem_bist_ctrl #(.DW(DW), .AW(AW), .RD_LAT(2), .BG(BG)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .fail(fail1),
        .mem_d_in(d_in1), .mem_addr(addr1), .mem_en_wr(wr1), .mem_en_rd(rd1),
        .mem_d_out(d_out1), .err_addr(err_addr1), .err_exp(err_exp1),
        .err_got(err_got1), .err_cnt(err_cnt1)
    );

    // ---------------- memory models ----------------
    logic          f_en;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_sa1, f_sa0;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (f_en && a == f_addr) return (v | f_sa1) & ~f_sa0;
        return v;
    endfunction

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] pipe1;

    always @(posedge clk) begin
        if (wr0) mem0[addr0] <= d_in0;
        if (rd0) d_out0 <= faulty(addr0, mem0[addr0]);
    end

    always @(posedge clk) begin
        if (wr1) mem1[addr1] <= d_in1;
        if (rd1) pipe1 <= mem1[addr1];
        d_out1 <= pipe1;
    end

    // ---------------- scoreboard / checks ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // March C- written as text: U/D direction, then r/w op with data value 0/1.
    string march [6] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Dr0"};

    logic [OPW-1:0] exp_q [$];
    bit             m_fail;
    int             m_cnt;
    logic [AW-1:0]  m_eaddr;
    logic [DW-1:0]  m_eexp, m_egot;

    function automatic logic [OPW-1:0] op(input logic w, input logic r,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {w, r, a, d};
    endfunction

    task automatic build_model(input int lat, input bit use_fault);
        logic [DW-1:0] mm [DEPTH];
        string         s;
        int            a, i;
        logic [AW-1:0] aa;
        logic [DW-1:0] pat, wpat, got;
        exp_q.delete();
        m_fail = 0; m_cnt = 0; m_eaddr = '0; m_eexp = '0; m_egot = '0;
        foreach (mm[k]) mm[k] = '0;
        foreach (march[e]) begin
            s = march[e];
            for (int k = 0; k < DEPTH; k++) begin
                a  = (s[0] == "U") ? k : DEPTH - 1 - k;
                aa = AW'(a);
                i  = 1;
                while (i < s.len()) begin
                    pat = (s[i+1] == "1") ? ~BG : BG;
                    if (s[i] == "w") begin
                        exp_q.push_back(op(1'b1, 1'b0, aa, pat));
                        mm[a] = pat;
                        i += 2;
                    end else begin
                        got = (use_fault && f_en && aa == f_addr) ? ((mm[a] | f_sa1) & ~f_sa0) : mm[a];
                        if (got !== pat) begin
                            if (!m_fail) begin m_eaddr = aa; m_eexp = pat; m_egot = got; end
                            m_fail = 1;
                            if (m_cnt < 255) m_cnt++;
                        end
                        exp_q.push_back(op(1'b0, 1'b1, aa, '0));
                        for (int w = 1; w < lat; w++) exp_q.push_back(op(1'b0, 1'b0, aa, '0));
                        if (i + 2 < s.len()) begin
                            wpat = (s[i+3] == "1") ? ~BG : BG;
                            exp_q.push_back(op(1'b1, 1'b0, aa, wpat));
                            mm[a] = wpat;
                            i += 4;
                        end else begin
                            exp_q.push_back(op(1'b0, 1'b0, aa, '0));
                            i += 2;
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- driver / monitor ----------------
    task automatic drive_start(input bit sel, input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    function automatic logic [OPW-1:0] sample_op(input bit sel);
        return sel ? {wr1, rd1, addr1, d_in1} : {wr0, rd0, addr0, d_in0};
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    int overlap;

    // Starts a run, compares every busy cycle against exp_q; returns at the first non-busy negedge.
    task automatic run_bist(input string name, input bit sel, input int restart_at,
                            output int cycles, output int last_rd_addr);
        int             bad;
        string          first;
        logic [OPW-1:0] g, e;
        bad = 0; first = ""; cycles = 0; last_rd_addr = -1; overlap = 0;
        @(posedge clk); #1 drive_start(sel, 1'b1);
        @(posedge clk); #1 drive_start(sel, 1'b0);
        while (cycles < 2000) begin
            @(negedge clk);
            if (cycles == restart_at)          drive_start(sel, 1'b1);
            else if (cycles == restart_at + 1) drive_start(sel, 1'b0);
            if (!busy_of(sel)) break;
            if (cycles == 0 && !sel) begin
                check({name, "_start_clears_done"}, done0, 1'b0);
                check({name, "_start_clears_fail"}, fail0, 1'b0);
                check({name, "_start_clears_cnt"}, err_cnt0, 8'd0);
            end
            g = sample_op(sel);
            if (g[OPW-1] && g[OPW-2]) overlap++;
            if (g[OPW-2]) last_rd_addr = int'(g[DW+AW-1:DW]);
            if (exp_q.size() == 0) begin
                bad++;
                if (first == "") first = $sformatf("extra busy cycle %0d", cycles);
            end else begin
                e = exp_q.pop_front();
                if (!e[OPW-1]) g[DW-1:0] = '0;
                if (g !== e) begin
                    bad++;
                    if (first == "") first = $sformatf("cycle %0d op 0x%0h vs 0x%0h", cycles, g, e);
                end
            end
            cycles++;
        end
        drive_start(sel, 1'b0);
        if (bad != 0) $display("  %s first divergence: %s", name, first);
        check({name, "_trace_mismatches"}, bad, 0);
    endtask

    task automatic check_end(input string name, input int cycles, input int exp_cycles,
                             input logic exp_fail, input logic [7:0] e_cnt, input logic [AW-1:0] e_addr,
                             input logic [DW-1:0] e_exp, input logic [DW-1:0] e_got);
        check({name, "_busy_cycles"}, cycles, exp_cycles);
        check({name, "_done"}, done0, 1'b1);
        check({name, "_busy_low"}, busy0, 1'b0);
        check({name, "_fail"}, fail0, exp_fail);
        check({name, "_err_cnt"}, err_cnt0, LOG_EN ? e_cnt : 8'd0);
        check({name, "_err_addr"}, err_addr0, LOG_EN ? e_addr : '0);
        check({name, "_err_exp"}, err_exp0, LOG_EN ? e_exp : '0);
        check({name, "_err_got"}, err_got0, LOG_EN ? e_got : '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic          fen;
        logic [AW-1:0] faddr;
        logic [DW-1:0] sa1, sa0;
        int            restart_at;
        logic          exp_fail;
        logic [7:0]    exp_cnt;
        logic [AW-1:0] exp_eaddr;
        logic [DW-1:0] exp_eexp, exp_egot;
    } vec_t;

    function automatic vec_t mk(input string n, input logic fen, input logic [AW-1:0] fa,
                                input logic [DW-1:0] s1, input logic [DW-1:0] s0, input int ra,
                                input logic ef, input logic [7:0] ec, input logic [AW-1:0] ea,
                                input logic [DW-1:0] ee, input logic [DW-1:0] eg);
        vec_t v;
        v.name = n; v.fen = fen; v.faddr = fa; v.sa1 = s1; v.sa0 = s0; v.restart_at = ra;
        v.exp_fail = ef; v.exp_cnt = ec; v.exp_eaddr = ea; v.exp_eexp = ee; v.exp_egot = eg;
        return v;
    endfunction

    vec_t vecs [4];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles, last_rd, pre;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        f_en = 1'b0; f_addr = '0; f_sa1 = '0; f_sa0 = '0;

        vecs[0] = mk("clean",      1'b0, 4'd0,  32'h0, 32'h0,          -1, 1'b0, 8'd0, 4'd0,  32'h0,          32'h0);
        vecs[1] = mk("sa1_b3_a5",  1'b1, 4'd5,  32'h8, 32'h0,          -1, 1'b1, 8'd3, 4'd5,  32'h0,          32'h8);
        vecs[2] = mk("sa0_a15",    1'b1, 4'd15, 32'h0, 32'hFFFF_FFFF,  -1, 1'b1, 8'd2, 4'd15, 32'hFFFF_FFFF,  32'h0);
        vecs[3] = mk("restart_50", 1'b0, 4'd0,  32'h0, 32'h0,          50, 1'b0, 8'd0, 4'd0,  32'h0,          32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_fail", fail0, 1'b0);
        check("rst_en_wr", wr0, 1'b0);
        check("rst_en_rd", rd0, 1'b0);
        check("rst_addr", addr0, '0);
        check("rst_d_in", d_in0, '0);
        check("rst_err_cnt", err_cnt0, 8'd0);
        check("rst_err_addr", err_addr0, '0);
        check("rst_err_exp", err_exp0, '0);
        check("rst_err_got", err_got0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", busy0, 1'b0);

        // Directed table
        foreach (vecs[v]) begin
            f_en = vecs[v].fen; f_addr = vecs[v].faddr; f_sa1 = vecs[v].sa1; f_sa0 = vecs[v].sa0;
            build_model(1, 1'b1);
            run_bist(vecs[v].name, 1'b0, vecs[v].restart_at, cycles, last_rd);
            check_end(vecs[v].name, cycles, 176, vecs[v].exp_fail, vecs[v].exp_cnt,
                      vecs[v].exp_eaddr, vecs[v].exp_eexp, vecs[v].exp_egot);
            if (v == 0) check("clean_last_read_addr", last_rd, 0);
            repeat (3) @(negedge clk);
            check({vecs[v].name, "_done_held"}, done0, 1'b1);
        end

        // Random fault runs against the model
        for (int r = 0; r < 6; r++) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = AW'($urandom_range(0, DEPTH - 1));
            f_sa1  = ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            f_sa0  = ($urandom_range(0, 1) != 0) ? ($urandom & $urandom) : '0;
            build_model(1, 1'b1);
            cycles = exp_q.size();
            pre = cycles;
            run_bist($sformatf("rand%0d", r), 1'b0, -1, cycles, last_rd);
            check_end($sformatf("rand%0d", r), cycles, pre, m_fail, 8'(m_cnt), m_eaddr, m_eexp, m_egot);
        end

        // Asynchronous reset in the middle of E3, then a clean rerun
        f_en = 1'b0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int c = 0; c < 90; c++) @(negedge clk);
        check("midrun_active_before_reset", wr0 | rd0, 1'b1);
        rst = 1'b0;
        #1;
        check("midrun_rst_en_wr", wr0, 1'b0);
        check("midrun_rst_en_rd", rd0, 1'b0);
        check("midrun_rst_busy", busy0, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_done", done0, 1'b0);
        check("after_rst_busy", busy0, 1'b0);
        build_model(1, 1'b0);
        run_bist("post_reset", 1'b0, -1, cycles, last_rd);
        check_end("post_reset", cycles, 176, 1'b0, 8'd0, '0, '0, '0);

        // Two-cycle read latency instance
        build_model(2, 1'b0);
        run_bist("lat2", 1'b1, -1, cycles, last_rd);
        check("lat2_busy_cycles", cycles, 256);
        check("lat2_rd_wr_overlap", overlap, 0);
        check("lat2_done", done1, 1'b1);
        check("lat2_fail", fail1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
